joy_autoread: RTL and testbench
===============================

# joy_autoread

Controller-port initiator for the SNES CPU side: on each vblank-start pulse it latches both controller ports, clocks out 16 serial bits per data line, and commits four 16-bit joypad words atomically. It drives the same latch/clock/data lines that the per-port `ioport` responders serve, and sits between the CPU I/O register block (auto-read enable, busy flag, joypad result registers) and the two ports.

## Interface
Parameters:
- `LATCH_CYCLES`, default 12: number of `clk_sys` cycles that `JOY_STRB` stays high.
- `HALF_CYCLES`, default 96: number of cycles in each low phase and each high phase of the port clock.

Ports (name, direction, width, meaning):
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: auto-read enable.
- `start` in 1: single-cycle vblank-start pulse.
- `manual_latch` in 1: CPU manual latch bit.
- `busy` out 1: auto-read in progress.
- `done` out 1: single-cycle pulse when results are committed.
- `JOY_STRB` out 1: latch to both ports.
- `JOY1_CLK` out 1, `JOY2_CLK` out 1: port clocks; idle high.
- `JOY1_DI` in 2, `JOY2_DI` in 2: port data lines D0 and D1, active-high.
- `joy1_d0`, `joy1_d1`, `joy2_d0`, `joy2_d1` out 16: committed words.
- `joy_present` out 2: bit0 is port 1, bit1 is port 2.

## Operation
- States: IDLE, LATCH, CLK_LO, CLK_HI, (PRESENT_LO, PRESENT_HI), COMMIT.
- IDLE:
  - `JOY_STRB` = `manual_latch`.
  - Both port clocks are high.
  - `start & enable` moves to LATCH.
- LATCH:
  - `JOY_STRB` = 1 for `LATCH_CYCLES` cycles.
  - Then go to CLK_LO with bit index 0.
- CLK_LO:
  - On entry, sample all four DI lines into shadow shift registers, MSB-first. Bit 0 lands in word bit 15 (the B button).
  - Both clocks are low for `HALF_CYCLES` cycles, then go to CLK_HI.
- CLK_HI:
  - Clocks are high for `HALF_CYCLES` cycles. The rising edge advances the controller.
  - If index = 15, go to COMMIT (or PRESENT_LO when the feature is compiled in). Otherwise increment the index and go to CLK_LO.
- COMMIT:
  - One cycle. Copy all shadows into the outputs, pulse `done`, return to IDLE.
  - Outputs never show partial results.
- `enable` is sampled only at `start`. Deasserting it mid-read does not abort the read.
- `start` while busy is ignored.
- `manual_latch` is ignored while busy.
- Reset has priority over everything, including mid-read:
  - State returns to IDLE; the counter and index clear.
  - `busy`, `done`, `JOY_STRB` = 0.
  - Port clocks = 1.
  - All words = 16'h0000.
  - `joy_present` = 2'b00 with the feature compiled in, 2'b11 without.
- `start` coincident with `reset` is ignored.

## Timing
- `start` at cycle 0 → `busy` = 1 and `JOY_STRB` = 1 from cycle 1.
- First sample and first clock-low edge occur at cycle 1+`LATCH_CYCLES`.
- `busy` stays high for exactly `LATCH_CYCLES + 32·HALF_CYCLES` cycles, plus `2·HALF_CYCLES` with the feature compiled in.
- `done` = 1 on the cycle `busy` falls. The outputs show new values on the same cycle.
- The phase counter counts from 0 to `N-1`. Its width is `$clog2` of `max(LATCH_CYCLES, HALF_CYCLES)`.
- Both parameters must be ≥ 1.

## Configuration
- `JOY_PRESENT_EN` defined:
  - After bit 15, perform one extra low/high clock pair (PRESENT_LO, PRESENT_HI).
  - `JOY1_DI[0]` and `JOY2_DI[0]`, sampled on entry to PRESENT_LO, are committed to `joy_present[0]` and `joy_present[1]` in COMMIT.
  - A standard pad returns 1 here; an empty port returns 0.
- `JOY_PRESENT_EN` undefined:
  - No extra clock pair.
  - `joy_present` is constant 2'b11.

## Structure
- Package `joy_pkg`:
  - State enum `joy_state_t`.
  - `JOY_BITS = 16`.
  - Reset values of the outputs.
- Sub-module `joy_shift`:
  - A two-lane, 16-bit shift register with `sample` and `clear` inputs.
  - Instantiated once per port.
- The top level holds the FSM, the phase counter and the commit logic.

## Test plan
All scenarios use `LATCH_CYCLES`=2 and `HALF_CYCLES`=2, with a behavioural pad model serving both ports.
- Port 1 pad with B+Start (serial pattern 1,0,0,1, then twelve 0s); pulse `start` with `enable`=1 → `joy1_d0`=16'h9000 and `joy2_d0`=16'h0000; `busy` high for 66 cycles; one `done` pulse.
- Port 2 pad with A+R on D0 and a D1 pattern of 0xFFFF → `joy2_d0`=16'h0090 and `joy2_d1`=16'hFFFF; `JOY2_CLK` shows exactly 16 low pulses of 2 cycles each.
- `start` pulsed again at cycle 10 of a read → ignored; exactly one `done`; busy length unchanged.
- `reset` asserted at cycle 20 of a read → next cycle: `busy`=0, `JOY_STRB`=0, clocks=1, words=0; no `done`.
- `enable`=0 with `start` → no latch, no clocks. Then `manual_latch`=1 → `JOY_STRB`=1 on the same cycle.
- `JOY_PRESENT_EN` with port 1 pad attached and port 2 empty (DI=0) → `joy_present`=2'b01; busy length 70 cycles.

Source files
------------

// File: rtl/joy_pkg.sv
// joy_pkg: shared types and constants for the controller-port auto-read block.
// Optional feature macro: JOY_PRESENT_EN (pad presence detection bit).
package joy_pkg;

  localparam int unsigned JOY_BITS  = 16;
  localparam int unsigned JOY_LANES = 2;
  localparam int unsigned IDX_W     = $clog2(JOY_BITS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_LO,
    ST_CLK_HI,
    ST_PRESENT_LO,
    ST_PRESENT_HI,
    ST_COMMIT
  } joy_state_t;

  localparam logic [JOY_BITS-1:0] WORD_RST = '0;

`ifdef JOY_PRESENT_EN
  localparam logic [1:0] PRESENT_RST = 2'b00;
`else
  localparam logic [1:0] PRESENT_RST = 2'b11;
`endif

endpackage

// File: rtl/joy_if.sv
// joy_if: latch/clock/data lines between the auto-read initiator and both ports.
interface joy_if;
  import joy_pkg::*;

  logic                 JOY_STRB;
  logic                 JOY1_CLK;
  logic                 JOY2_CLK;
  logic [JOY_LANES-1:0] JOY1_DI;
  logic [JOY_LANES-1:0] JOY2_DI;

  modport master (
    output JOY_STRB, JOY1_CLK, JOY2_CLK,
    input  JOY1_DI, JOY2_DI
  );

  modport slave (
    input  JOY_STRB, JOY1_CLK, JOY2_CLK,
    output JOY1_DI, JOY2_DI
  );

endinterface

// File: rtl/joy_shift.sv
// joy_shift: two-lane MSB-first shadow shift register for one controller port.
module joy_shift
  import joy_pkg::*;
(
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 sample,
  input  logic [JOY_LANES-1:0] di,
  output logic [JOY_BITS-1:0]  d0,
  output logic [JOY_BITS-1:0]  d1
);

  // First serial bit ends up in bit 15 after all shifts.
  always_ff @(posedge clk_sys) begin
    if (reset || clear) begin
      d0 <= WORD_RST;
      d1 <= WORD_RST;
    end else if (sample) begin
      d0 <= {d0[JOY_BITS-2:0], di[0]};
      d1 <= {d1[JOY_BITS-2:0], di[1]};
    end
  end

endmodule

// File: rtl/joy_autoread.sv
// joy_autoread: vblank-triggered serial read of both controller ports with
// atomic commit of four joypad words. Optional macro: JOY_PRESENT_EN.
module joy_autoread
  import joy_pkg::*;
#(
  parameter int unsigned LATCH_CYCLES = 12,
  parameter int unsigned HALF_CYCLES  = 96
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic                manual_latch,
  output logic                busy,
  output logic                done,
  joy_if.master               joy,
  output logic [JOY_BITS-1:0] joy1_d0,
  output logic [JOY_BITS-1:0] joy1_d1,
  output logic [JOY_BITS-1:0] joy2_d0,
  output logic [JOY_BITS-1:0] joy2_d1,
  output logic [1:0]          joy_present
);

  localparam int unsigned MAX_CYCLES = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  joy_state_t          state, next_state;
  logic [CNT_W-1:0]    cnt;
  logic [IDX_W-1:0]    idx;
  logic                phase_last;
  logic                sample, clear, commit;
  logic [JOY_BITS-1:0] sh1_d0, sh1_d1, sh2_d0, sh2_d1;
`ifdef JOY_PRESENT_EN
  logic                present_sample;
  logic [1:0]          present_sh;
`endif

  // Last cycle of the current timed phase.
  assign phase_last = (state == ST_LATCH) ? (cnt == CNT_W'(LATCH_CYCLES - 1))
                                          : (cnt == CNT_W'(HALF_CYCLES - 1));

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next-state and control strobes.
  always_comb begin
    next_state = state;
    sample     = 1'b0;
    clear      = 1'b0;
    commit     = 1'b0;
`ifdef JOY_PRESENT_EN
    present_sample = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start && enable) begin
          next_state = ST_LATCH;
          clear      = 1'b1;
        end
      end
      ST_LATCH: begin
        if (phase_last) begin
          next_state = ST_CLK_LO;
          sample     = 1'b1;
        end
      end
      ST_CLK_LO: begin
        if (phase_last) next_state = ST_CLK_HI;
      end
      ST_CLK_HI: begin
        if (phase_last) begin
          if (idx == IDX_W'(JOY_BITS - 1)) begin
`ifdef JOY_PRESENT_EN
            next_state     = ST_PRESENT_LO;
            present_sample = 1'b1;
`else
            next_state = ST_COMMIT;
            commit     = 1'b1;
`endif
          end else begin
            next_state = ST_CLK_LO;
            sample     = 1'b1;
          end
        end
      end
      ST_PRESENT_LO: begin
        if (phase_last) next_state = ST_PRESENT_HI;
      end
      ST_PRESENT_HI: begin
        if (phase_last) begin
          next_state = ST_COMMIT;
          commit     = 1'b1;
        end
      end
      ST_COMMIT: next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Phase counter restarts on every state change.
  always_ff @(posedge clk_sys) begin
    if (reset || (next_state != state)) cnt <= '0;
    else if (busy)                      cnt <= cnt + CNT_W'(1);
  end

  // Bit index advances at the end of each non-final high phase.
  always_ff @(posedge clk_sys) begin
    if (reset || clear)
      idx <= '0;
    else if ((state == ST_CLK_HI) && phase_last && (idx != IDX_W'(JOY_BITS - 1)))
      idx <= idx + IDX_W'(1);
  end

  // Status and port-line decode from the registered state.
  assign busy         = (state == ST_LATCH) || (state == ST_CLK_LO) || (state == ST_CLK_HI) ||
                        (state == ST_PRESENT_LO) || (state == ST_PRESENT_HI);
  assign done         = (state == ST_COMMIT);
  assign joy.JOY_STRB = (state == ST_IDLE) ? (manual_latch && !reset) : (state == ST_LATCH);
  assign joy.JOY1_CLK = !((state == ST_CLK_LO) || (state == ST_PRESENT_LO));
  assign joy.JOY2_CLK = !((state == ST_CLK_LO) || (state == ST_PRESENT_LO));

  joy_shift u_shift1 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (clear),
    .sample  (sample),
    .di      (joy.JOY1_DI),
    .d0      (sh1_d0),
    .d1      (sh1_d1)
  );

  joy_shift u_shift2 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .clear   (clear),
    .sample  (sample),
    .di      (joy.JOY2_DI),
    .d0      (sh2_d0),
    .d1      (sh2_d1)
  );

  // Results load on the edge into COMMIT so they appear alongside done.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      joy1_d0 <= WORD_RST;
      joy1_d1 <= WORD_RST;
      joy2_d0 <= WORD_RST;
      joy2_d1 <= WORD_RST;
    end else if (commit) begin
      joy1_d0 <= sh1_d0;
      joy1_d1 <= sh1_d1;
      joy2_d0 <= sh2_d0;
      joy2_d1 <= sh2_d1;
    end
  end

`ifdef JOY_PRESENT_EN
  // Presence bits: D0 of each port after the extra clock, committed with the words.
  always_ff @(posedge clk_sys) begin
    if (reset || clear) present_sh <= 2'b00;
    else if (present_sample) present_sh <= {joy.JOY2_DI[0], joy.JOY1_DI[0]};
  end

  // Committed presence bits.
  always_ff @(posedge clk_sys) begin
    if (reset)       joy_present <= PRESENT_RST;
    else if (commit) joy_present <= present_sh;
  end
`else
  assign joy_present = PRESENT_RST;
`endif

endmodule

// File: tb/tb_joy_autoread.sv
// tb_joy_autoread: directed bench for joy_autoread with a behavioural pad on each port.
// Build with JOY_PRESENT_EN defined to exercise the presence-detect variant.
module tb_joy_autoread;

  localparam int unsigned LC = 2;
  localparam int unsigned HC = 2;
`ifdef JOY_PRESENT_EN
  localparam int         EXP_BUSY     = 70;
  localparam int         EXP_LO       = 17;
  localparam logic [1:0] EXP_PRES_RST = 2'b00;
  localparam logic [1:0] EXP_PRES_P1  = 2'b01;
`else
  localparam int         EXP_BUSY     = 66;
  localparam int         EXP_LO       = 16;
  localparam logic [1:0] EXP_PRES_RST = 2'b11;
  localparam logic [1:0] EXP_PRES_P1  = 2'b11;
`endif

  logic        clk_sys = 1'b0;
  logic        reset, enable, start, manual_latch;
  logic        busy, done;
  logic [15:0] joy1_d0, joy1_d1, joy2_d0, joy2_d1;
  logic [1:0]  joy_present;

  joy_if jif ();

  joy_autoread #(.LATCH_CYCLES(LC), .HALF_CYCLES(HC)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .enable       (enable),
    .start        (start),
    .manual_latch (manual_latch),
    .busy         (busy),
    .done         (done),
    .joy          (jif),
    .joy1_d0      (joy1_d0),
    .joy1_d1      (joy1_d1),
    .joy2_d0      (joy2_d0),
    .joy2_d1      (joy2_d1),
    .joy_present  (joy_present)
  );

  always #5 clk_sys = ~clk_sys;

  // Pad model: load on latch, shift on rising port clock, 1s fill behind.
  logic [15:0] pat1_d0 = '0, pat1_d1 = '0, pat2_d0 = '0, pat2_d1 = '0;
  logic        att1 = 1'b0, att2 = 1'b0;
  logic [15:0] p1_s0 = '0, p1_s1 = '0, p2_s0 = '0, p2_s1 = '0;
  logic        p1_prev = 1'b1, p2_prev = 1'b1;

  always @(posedge clk_sys) begin
    p1_prev <= jif.JOY1_CLK;
    if (jif.JOY_STRB) begin
      p1_s0 <= pat1_d0;
      p1_s1 <= pat1_d1;
    end else if (jif.JOY1_CLK && !p1_prev) begin
      p1_s0 <= {p1_s0[14:0], 1'b1};
      p1_s1 <= {p1_s1[14:0], 1'b1};
    end
  end

  always @(posedge clk_sys) begin
    p2_prev <= jif.JOY2_CLK;
    if (jif.JOY_STRB) begin
      p2_s0 <= pat2_d0;
      p2_s1 <= pat2_d1;
    end else if (jif.JOY2_CLK && !p2_prev) begin
      p2_s0 <= {p2_s0[14:0], 1'b1};
      p2_s1 <= {p2_s1[14:0], 1'b1};
    end
  end

  assign jif.JOY1_DI = att1 ? {p1_s1[15], p1_s0[15]} : 2'b00;
  assign jif.JOY2_DI = att2 ? {p2_s1[15], p2_s0[15]} : 2'b00;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int busy_len, done_cnt, lo_pulses, bad_lo, strb_len, strb_busy, first_lo;

  // One start pulse (cycle 0), then observe n_cyc cycles; optional restart/reset cycles.
  task automatic run_read(input logic en, input int restart_at, input int reset_at, input int n_cyc);
    int run;
    run = 0;
    busy_len = 0; done_cnt = 0; lo_pulses = 0; bad_lo = 0;
    strb_len = 0; strb_busy = 0; first_lo = -1;
    enable = en;
    start  = 1'b1;
    for (int cyc = 1; cyc <= n_cyc; cyc++) begin
      @(posedge clk_sys); #1;
      if (busy) busy_len++;
      if (done) done_cnt++;
      if (jif.JOY_STRB) strb_len++;
      if (jif.JOY_STRB && busy) strb_busy++;
      if (!jif.JOY2_CLK) begin
        if (first_lo < 0) first_lo = cyc;
        run++;
      end else if (run > 0) begin
        lo_pulses++;
        if (run != int'(HC)) bad_lo++;
        run = 0;
      end
      start = (cyc == restart_at);
      reset = (cyc == reset_at);
      if (cyc == 5) enable = 1'b0;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; start = 1'b0; manual_latch = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check_eq("rst_busy",  32'(busy), 32'd0);
    check_eq("rst_done",  32'(done), 32'd0);
    check_eq("rst_strb",  32'(jif.JOY_STRB), 32'd0);
    check_eq("rst_clks",  32'({jif.JOY2_CLK, jif.JOY1_CLK}), 32'h3);
    check_eq("rst_words", {joy1_d0 | joy1_d1, joy2_d0 | joy2_d1}, 32'h0);
    check_eq("rst_pres",  32'(joy_present), 32'(EXP_PRES_RST));
    reset = 1'b0;
    @(posedge clk_sys); #1;

    // Port 1: B+Start; port 2 empty.
    att1 = 1'b1; pat1_d0 = 16'h9000; pat1_d1 = 16'h0000; att2 = 1'b0;
    run_read(1'b1, 0, 0, 80);
    check_eq("t1_busy_len", 32'(busy_len), 32'(EXP_BUSY));
    check_eq("t1_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t1_strb_len", 32'(strb_len), 32'd2);
    check_eq("t1_first_lo", 32'(first_lo), 32'd3);
    check_eq("t1_joy1_d0",  32'(joy1_d0), 32'h9000);
    check_eq("t1_joy1_d1",  32'(joy1_d1), 32'h0000);
    check_eq("t1_joy2_d0",  32'(joy2_d0), 32'h0000);
    check_eq("t1_joy2_d1",  32'(joy2_d1), 32'h0000);
    check_eq("t1_present",  32'(joy_present), 32'(EXP_PRES_P1));

    // Both pads: port 2 A+R with D1 all ones.
    pat1_d0 = 16'hA5C3; pat1_d1 = 16'h0F0F;
    att2 = 1'b1; pat2_d0 = 16'h0090; pat2_d1 = 16'hFFFF;
    run_read(1'b1, 0, 0, 80);
    check_eq("t2_lo_pulses", 32'(lo_pulses), 32'(EXP_LO));
    check_eq("t2_bad_lo",    32'(bad_lo), 32'd0);
    check_eq("t2_joy1_d0",   32'(joy1_d0), 32'hA5C3);
    check_eq("t2_joy1_d1",   32'(joy1_d1), 32'h0F0F);
    check_eq("t2_joy2_d0",   32'(joy2_d0), 32'h0090);
    check_eq("t2_joy2_d1",   32'(joy2_d1), 32'hFFFF);
    check_eq("t2_present",   32'(joy_present), 32'h3);

    // Second start mid-read is ignored.
    pat1_d0 = 16'h5A3C;
    run_read(1'b1, 10, 0, 80);
    check_eq("t3_busy_len", 32'(busy_len), 32'(EXP_BUSY));
    check_eq("t3_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("t3_joy1_d0",  32'(joy1_d0), 32'h5A3C);

    // Reset at cycle 20 of a read aborts it and clears results.
    run_read(1'b1, 0, 20, 40);
    check_eq("t4_busy_len", 32'(busy_len), 32'd20);
    check_eq("t4_done_cnt", 32'(done_cnt), 32'd0);
    check_eq("t4_busy",     32'(busy), 32'd0);
    check_eq("t4_strb",     32'(jif.JOY_STRB), 32'd0);
    check_eq("t4_clks",     32'({jif.JOY2_CLK, jif.JOY1_CLK}), 32'h3);
    check_eq("t4_words",    {joy1_d0 | joy1_d1, joy2_d0 | joy2_d1}, 32'h0);
    check_eq("t4_present",  32'(joy_present), 32'(EXP_PRES_RST));

    // Start with auto-read disabled does nothing.
    run_read(1'b0, 0, 0, 20);
    check_eq("t5_busy_len", 32'(busy_len), 32'd0);
    check_eq("t5_strb_len", 32'(strb_len), 32'd0);
    check_eq("t5_lo",       32'(lo_pulses), 32'd0);
    check_eq("t5_done_cnt", 32'(done_cnt), 32'd0);

    // Manual latch passes straight through while idle.
    manual_latch = 1'b1;
    #1;
    check_eq("t5_manual_hi", 32'(jif.JOY_STRB), 32'd1);
    manual_latch = 1'b0;
    #1;
    check_eq("t5_manual_lo", 32'(jif.JOY_STRB), 32'd0);

    // Manual latch held during a read only shows during the latch phase.
    @(posedge clk_sys); #1;
    manual_latch = 1'b1;
    run_read(1'b1, 0, 0, 80);
    check_eq("t6_strb_busy", 32'(strb_busy), 32'd2);
    check_eq("t6_done_cnt",  32'(done_cnt), 32'd1);
    check_eq("t6_joy2_d0",   32'(joy2_d0), 32'h0090);
    manual_latch = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
